// File: rtl/booth_pkg.sv
// Shared constants and helpers for the radix-2 Booth sequential multiplier.
package booth_pkg;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [1:0] SEL_NOP = 2'd0;
  localparam logic [1:0] SEL_ADD = 2'd1;
  localparam logic [1:0] SEL_SUB = 2'd2;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Booth recoding of the {Q[0], Q-1} bit pair.
  function automatic logic [1:0] booth_sel(input logic q0, input logic qm1);
    case ({q0, qm1})
      2'b01:   return SEL_ADD;
      2'b10:   return SEL_SUB;
      default: return SEL_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_seq_multiplier_if.sv
// Start/done handshake and operand/result bus of the Booth multiplier.
interface booth_seq_multiplier_if #(
  parameter int WIDTH = 4
);
  logic                   i_start;
  logic [WIDTH-1:0]       i_multiplicand;
  logic [WIDTH-1:0]       i_multiplier;
  logic                   o_busy;
  logic                   o_done;
  logic [2*WIDTH-1:0]     o_product;

  modport master (
    output i_start, i_multiplicand, i_multiplier,
    input  o_busy, o_done, o_product
  );

  modport slave (
    input  i_start, i_multiplicand, i_multiplier,
    output o_busy, o_done, o_product
  );
endinterface

// File: rtl/booth_aq_shift.sv
// A/Q/Q-1 register: load, or one Booth add/sub plus arithmetic right shift per cycle.
module booth_aq_shift
  import booth_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk_i,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic               shift_i,
  input  logic [WIDTH:0]     m_i,
  input  logic [WIDTH-1:0]   q_i,
  output logic [2*WIDTH-1:0] prod_nxt_o
);

  logic [WIDTH:0]   a_q, a_d, a_sum, a_sh;
  logic [WIDTH-1:0] q_q, q_d, q_sh;
  logic             q1_q, q1_d, q1_sh;

  always_comb begin
    case (booth_sel(q_q[0], q1_q))
      SEL_ADD: a_sum = a_q + m_i;
      SEL_SUB: a_sum = a_q - m_i;
      default: a_sum = a_q;
    endcase
    // A's sign bit is replicated, A[0] falls into Q, Q[0] into Q-1.
    {a_sh, q_sh, q1_sh} = {a_sum[WIDTH], a_sum, q_q};
  end

  always_comb begin
    a_d  = a_q;
    q_d  = q_q;
    q1_d = q1_q;
    if (load_i) begin
      a_d  = '0;
      q_d  = q_i;
      q1_d = 1'b0;
    end else if (shift_i) begin
      a_d  = a_sh;
      q_d  = q_sh;
      q1_d = q1_sh;
    end
  end

  assign prod_nxt_o = {a_sh[WIDTH-1:0], q_sh};

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      a_q  <= '0;
      q_q  <= '0;
      q1_q <= 1'b0;
    end else begin
      a_q  <= a_d;
      q_q  <= q_d;
      q1_q <= q1_d;
    end
  end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential signed radix-2 Booth multiplier: FSM, step counter, M register and result.
module booth_seq_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                   i_clk,
  input  logic                   clr,
  booth_seq_multiplier_if.slave  bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [0:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     m_q, m_d;
  logic [2*WIDTH-1:0] product_q, product_d, prod_nxt;
  logic               done_q, done_d;
  logic               load, shift;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_d       = m_q;
    product_d = product_q;
    done_d    = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          load    = 1'b1;
          m_d     = {bus.i_multiplicand[WIDTH-1], bus.i_multiplicand};
          cnt_d   = CNT_W'(WIDTH);
          state_d = RUN;
        end
      end
      default: begin
        shift = 1'b1;
        cnt_d = cnt_q - 1'b1;
        // Last step: capture the freshly shifted A/Q pair directly.
        if (cnt_q == CNT_W'(1)) begin
          product_d = prod_nxt;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (clr) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      m_q       <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_q       <= m_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  booth_aq_shift #(.WIDTH(WIDTH)) u_aq (
    .clk_i      (i_clk),
    .clr_i      (clr),
    .load_i     (load),
    .shift_i    (shift),
    .m_i        (m_q),
    .q_i        (bus.i_multiplier),
    .prod_nxt_o (prod_nxt)
  );

  assign bus.o_busy    = (state_q == RUN);
  assign bus.o_done    = done_q;
  assign bus.o_product = product_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed and random checks of the Booth multiplier at WIDTH=4 and WIDTH=8.
module tb_booth_seq_multiplier;

  logic i_clk = 1'b0;
  logic clr   = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 i_clk = ~i_clk;

  booth_seq_multiplier_if #(.WIDTH(4)) b4 ();
  booth_seq_multiplier_if #(.WIDTH(8)) b8 ();

  booth_seq_multiplier #(.WIDTH(4)) dut4 (.i_clk(i_clk), .clr(clr), .bus(b4));
  booth_seq_multiplier #(.WIDTH(8)) dut8 (.i_clk(i_clk), .clr(clr), .bus(b8));

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start on the next edge, scramble operands afterwards, check busy/done timing and result.
  task automatic run4(input string tag, input logic [3:0] m, input logic [3:0] q,
                      input logic [7:0] exp);
    b4.i_multiplicand = m;
    b4.i_multiplier   = q;
    b4.i_start        = 1'b1;
    tick();
    b4.i_start        = 1'b0;
    b4.i_multiplicand = ~m;
    b4.i_multiplier   = ~q;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_busy"}, 32'(b4.o_busy), 32'd1);
      chk({tag, "_nodone"}, 32'(b4.o_done), 32'd0);
      tick();
    end
    chk({tag, "_done"}, 32'(b4.o_done), 32'd1);
    chk({tag, "_idle"}, 32'(b4.o_busy), 32'd0);
    chk({tag, "_prod"}, 32'(b4.o_product), 32'(exp));
  endtask

  task automatic op8(input string tag, input logic [7:0] m, input logic [7:0] q,
                     input logic [15:0] exp);
    int lat;
    b8.i_multiplicand = m;
    b8.i_multiplier   = q;
    b8.i_start        = 1'b1;
    tick();
    b8.i_start = 1'b0;
    lat = 1;
    while (!b8.o_done && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd9);
    chk({tag, "_prod"}, 32'(b8.o_product), 32'(exp));
  endtask

  initial begin
    logic signed [7:0]  rm, rq;
    logic signed [15:0] rp;
    b4.i_start = 1'b0; b4.i_multiplicand = '0; b4.i_multiplier = '0;
    b8.i_start = 1'b0; b8.i_multiplicand = '0; b8.i_multiplier = '0;
    clr = 1'b1;
    tick(); tick();
    chk("rst_busy4", 32'(b4.o_busy), 32'd0);
    chk("rst_done4", 32'(b4.o_done), 32'd0);
    chk("rst_prod4", 32'(b4.o_product), 32'd0);
    chk("rst_prod8", 32'(b8.o_product), 32'd0);
    clr = 1'b0;
    tick();

    run4("m3q-2", 4'h3, 4'hE, 8'hFA);
    tick();
    chk("done_pulse", 32'(b4.o_done), 32'd0);
    chk("prod_hold", 32'(b4.o_product), 32'hFA);
    run4("m-8q-8", 4'h8, 4'h8, 8'h40);
    run4("m7q7", 4'h7, 4'h7, 8'h31);
    run4("m0q-5", 4'h0, 4'hB, 8'h00);
    run4("m-5q0", 4'hB, 4'h0, 8'h00);
    run4("m-1q-1", 4'hF, 4'hF, 8'h01);

    // Start re-asserted during RUN must be ignored.
    b4.i_multiplicand = 4'h3; b4.i_multiplier = 4'hE; b4.i_start = 1'b1;
    tick();
    b4.i_multiplicand = 4'h5; b4.i_multiplier = 4'h5;
    tick(); tick();
    b4.i_start = 1'b0;
    tick(); tick();
    chk("ign_done", 32'(b4.o_done), 32'd1);
    chk("ign_prod", 32'(b4.o_product), 32'hFA);
    // Start during the done cycle is accepted.
    run4("b2b", 4'h5, 4'h5, 8'h19);

    // Abort in the second RUN cycle.
    b4.i_multiplicand = 4'h3; b4.i_multiplier = 4'hE; b4.i_start = 1'b1;
    tick();
    b4.i_start = 1'b0;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("abort_busy", 32'(b4.o_busy), 32'd0);
    chk("abort_prod", 32'(b4.o_product), 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk("abort_nodone", 32'(b4.o_done), 32'd0);
      tick();
    end
    run4("m2q3", 4'h2, 4'h3, 8'h06);

    op8("w8_min", 8'h80, 8'h80, 16'h4000);
    op8("w8_m7fq80", 8'h7F, 8'h80, 16'hC080);
    for (int i = 0; i < 1000; i++) begin
      rm = 8'($urandom);
      rq = 8'($urandom);
      rp = rm * rq;
      op8("w8_rand", rm, rq, rp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
